// File: rtl/core_pkg.sv
// Shared constants and bundle types for the RV32I core pipeline registers.
package core_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned RESULT_SRC_W = 2;
    localparam int unsigned ALU_CTRL_W   = 3;
    localparam int unsigned REG_IDX_W    = 5;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic                    jump;
        logic                    branch;
        logic                    alu_src;
        logic [RESULT_SRC_W-1:0] result_src;
        logic [ALU_CTRL_W-1:0]   alu_control;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                ctrl;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [XLEN-1:0]      imm_ext;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pc_plus4;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
    } idex_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (priority over enable), and load enable.
module pipe_reg #(
    parameter int unsigned   W       = 32,
    parameter logic [W-1:0]  RST_VAL = '0,
    parameter logic [W-1:0]  CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = CLR_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with hazard hold/bubble handling
// plus saturating stall and flush event counters.
module pipe_front_regs
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    StallF,
    input  logic                    StallD,
    input  logic                    FlushD,
    input  logic                    FlushE,
    input  logic [31:0]             PCNextF,
    input  logic [31:0]             InstrF,
    input  logic [31:0]             PCPlus4F,
    output logic [31:0]             PCF,
    output logic [31:0]             InstrD,
    output logic [31:0]             PCD,
    output logic [31:0]             PCPlus4D,
    input  logic                    RegWriteD,
    input  logic                    MemWriteD,
    input  logic                    JumpD,
    input  logic                    BranchD,
    input  logic                    ALUSrcD,
    input  logic [RESULT_SRC_W-1:0] ResultSrcD,
    input  logic [ALU_CTRL_W-1:0]   ALUControlD,
    input  logic [31:0]             RD1D,
    input  logic [31:0]             RD2D,
    input  logic [31:0]             ImmExtD,
    input  logic [31:0]             PCD_E,
    input  logic [31:0]             PCPlus4D_E,
    input  logic [REG_IDX_W-1:0]    Rs1D,
    input  logic [REG_IDX_W-1:0]    Rs2D,
    input  logic [REG_IDX_W-1:0]    RdD,
    output logic                    RegWriteE,
    output logic                    MemWriteE,
    output logic                    JumpE,
    output logic                    BranchE,
    output logic                    ALUSrcE,
    output logic [RESULT_SRC_W-1:0] ResultSrcE,
    output logic [ALU_CTRL_W-1:0]   ALUControlE,
    output logic [31:0]             RD1E,
    output logic [31:0]             RD2E,
    output logic [31:0]             ImmExtE,
    output logic [31:0]             PCE,
    output logic [31:0]             PCPlus4E,
    output logic [REG_IDX_W-1:0]    Rs1E,
    output logic [REG_IDX_W-1:0]    Rs2E,
    output logic [REG_IDX_W-1:0]    RdE,
    input  logic                    CntClr,
    output logic [CNT_W-1:0]        StallCount,
    output logic [CNT_W-1:0]        FlushCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_reg #(
        .W       (32),
        .RST_VAL (RESET_PC),
        .CLR_VAL ('0)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (~StallF),
        .clr   (1'b0),
        .d     (PCNextF),
        .q     (PCF)
    );

    // Instruction field sits apart so its reset/flush value can be the NOP.
    pipe_reg #(
        .W       (32),
        .RST_VAL (NOP_INSTR),
        .CLR_VAL (NOP_INSTR)
    ) u_ifid_instr (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (FlushD),
        .d     (InstrF),
        .q     (InstrD)
    );

    pipe_reg #(
        .W       (64),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_ifid_pc (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (FlushD),
        .d     ({PCF, PCPlus4F}),
        .q     ({PCD, PCPlus4D})
    );

    idex_t idex_in;
    idex_t idex_out;

    always_comb begin
        idex_in                  = '0;
        idex_in.ctrl.reg_write   = RegWriteD;
        idex_in.ctrl.mem_write   = MemWriteD;
        idex_in.ctrl.jump        = JumpD;
        idex_in.ctrl.branch      = BranchD;
        idex_in.ctrl.alu_src     = ALUSrcD;
        idex_in.ctrl.result_src  = ResultSrcD;
        idex_in.ctrl.alu_control = ALUControlD;
        idex_in.rd1              = RD1D;
        idex_in.rd2              = RD2D;
        idex_in.imm_ext          = ImmExtD;
        idex_in.pc               = PCD_E;
        idex_in.pc_plus4         = PCPlus4D_E;
        idex_in.rs1              = Rs1D;
        idex_in.rs2              = Rs2D;
        idex_in.rd               = RdD;
    end

    // A flushed ID/EX is all-zero: no write, no forward match, no load stall.
    pipe_reg #(
        .W       ($bits(idex_t)),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_idex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (idex_in),
        .q     (idex_out)
    );

    assign RegWriteE   = idex_out.ctrl.reg_write;
    assign MemWriteE   = idex_out.ctrl.mem_write;
    assign JumpE       = idex_out.ctrl.jump;
    assign BranchE     = idex_out.ctrl.branch;
    assign ALUSrcE     = idex_out.ctrl.alu_src;
    assign ResultSrcE  = idex_out.ctrl.result_src;
    assign ALUControlE = idex_out.ctrl.alu_control;
    assign RD1E        = idex_out.rd1;
    assign RD2E        = idex_out.rd2;
    assign ImmExtE     = idex_out.imm_ext;
    assign PCE         = idex_out.pc;
    assign PCPlus4E    = idex_out.pc_plus4;
    assign Rs1E        = idex_out.rs1;
    assign Rs2E        = idex_out.rs2;
    assign RdE         = idex_out.rd;

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallD && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            // A combined D+E flush is one redirect event.
            if ((FlushD || FlushE) && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: directed hazard patterns then random
// traffic, checked against a behavioural model of the pipeline registers.
module tb_pipe_front_regs;

    localparam int CNT_MAX = 15;

    typedef struct {
        logic [31:0]  pcf;
        logic [31:0]  instrd;
        logic [31:0]  pcd;
        logic [31:0]  pcp4d;
        logic [9:0]   ectl;
        logic [159:0] edata;
        logic [14:0]  eidx;
        int           sc;
        int           fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, FlushE, CntClr;
    logic [31:0] PCNextF, InstrF, PCPlus4F;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD_E, PCPlus4D_E;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [3:0]  StallCount, FlushCount;

    assign PCD_E      = PCD;
    assign PCPlus4D_E = PCPlus4D;

    pipe_front_regs #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .PCD_E(PCD_E), .PCPlus4D_E(PCPlus4D_E),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .CntClr(CntClr), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t m;
    obs_t sb[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t s;
        s.pcf    = PCF;
        s.instrd = InstrD;
        s.pcd    = PCD;
        s.pcp4d  = PCPlus4D;
        s.ectl   = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
        s.edata  = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E};
        s.eidx   = {Rs1E, Rs2E, RdE};
        s.sc     = int'(StallCount);
        s.fc     = int'(FlushCount);
        return s;
    endfunction

    task automatic check_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, "_pcf"},    160'(a.pcf),    160'(e.pcf));
        chk({tag, "_instrd"}, 160'(a.instrd), 160'(e.instrd));
        chk({tag, "_pcd"},    160'({a.pcd, a.pcp4d}), 160'({e.pcd, e.pcp4d}));
        chk({tag, "_ectl"},   160'(a.ectl),   160'(e.ectl));
        chk({tag, "_edata"},  a.edata,        e.edata);
        chk({tag, "_eidx"},   160'(a.eidx),   160'(e.eidx));
        chk({tag, "_stall_cnt"}, 160'(a.sc),  160'(e.sc));
        chk({tag, "_flush_cnt"}, 160'(a.fc),  160'(e.fc));
    endtask

    function automatic void model_reset();
        m = '{pcf: 32'h0, instrd: 32'h13, pcd: 0, pcp4d: 0, ectl: 0, edata: 0, eidx: 0, sc: 0, fc: 0};
    endfunction

    function automatic int sat_add(input int v, input logic inc, input logic clr);
        if (clr) return 0;
        if (inc) return (v + 1 > CNT_MAX) ? CNT_MAX : v + 1;
        return v;
    endfunction

    // Behavioural view of one clock edge, computed from the previous model state.
    function automatic void model_edge();
        obs_t p = m;
        if (!StallF) m.pcf = PCNextF;
        if (FlushD) begin
            m.instrd = 32'h13; m.pcd = 0; m.pcp4d = 0;
        end else if (!StallD) begin
            m.instrd = InstrF; m.pcd = p.pcf; m.pcp4d = PCPlus4F;
        end
        if (FlushE) begin
            m.ectl = 0; m.edata = 0; m.eidx = 0;
        end else begin
            m.ectl  = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD};
            m.edata = {RD1D, RD2D, ImmExtD, p.pcd, p.pcp4d};
            m.eidx  = {Rs1D, Rs2D, RdD};
        end
        m.sc = sat_add(p.sc, StallD, CntClr);
        m.fc = sat_add(p.fc, FlushD | FlushE, CntClr);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        sb.push_back(m);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) check_obs("sb", sample(), sb.pop_front());
    end

    task automatic clear_hazards();
        StallF = 0; StallD = 0; FlushD = 0; FlushE = 0; CntClr = 0;
    endtask

    task automatic rand_data();
        InstrF = $urandom; PCPlus4F = $urandom;
        {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD} = 5'($urandom);
        ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
        Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        clear_hazards();
        PCNextF = 32'h4;
        rand_data();
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_obs("reset", sample(), m);
        reset = 1'b1;

        // first edge loads PCNextF
        tick();
        chk("first_pcf", 160'(PCF), 160'(32'h4));

        // load-use stall
        PCNextF = 32'h8; InstrF = 32'h00A00093; RegWriteD = 1; RdD = 5'd1;
        tick();
        PCNextF = 32'hC; InstrF = 32'h00B00113;
        tick();
        PCNextF = 32'h10; InstrF = 32'h12345678;
        StallF = 1; StallD = 1; FlushE = 1;
        tick();
        chk("ld_pcf", 160'(PCF), 160'(32'hC));
        chk("ld_rd_e", 160'({RegWriteE, RdE}), 160'(0));
        chk("ld_stall_cnt", 160'(StallCount), 160'(1));
        chk("ld_flush_cnt", 160'(FlushCount), 160'(1));
        clear_hazards();

        // taken branch
        PCNextF = 32'h40;
        FlushD = 1; FlushE = 1;
        tick();
        chk("br_pcf", 160'(PCF), 160'(32'h40));
        chk("br_instr", 160'(InstrD), 160'(32'h13));
        chk("br_flush_cnt", 160'(FlushCount), 160'(2));
        clear_hazards();

        // flush beats stall, stall still counted
        rand_data();
        StallD = 1; FlushD = 1;
        tick();
        chk("prio_instr", 160'(InstrD), 160'(32'h13));
        chk("prio_stall_cnt", 160'(StallCount), 160'(2));
        clear_hazards();

        // saturation then clear
        StallD = 1;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            tick();
        end
        chk("sat_stall_cnt", 160'(StallCount), 160'(15));
        CntClr = 1;
        tick();
        chk("clr_stall_cnt", 160'(StallCount), 160'(0));
        clear_hazards();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_data();
            PCNextF = $urandom;
            StallF  = ($urandom_range(0, 99) < 20);
            StallD  = ($urandom_range(0, 99) < 20);
            FlushD  = ($urandom_range(0, 99) < 15);
            FlushE  = ($urandom_range(0, 99) < 15);
            CntClr  = ($urandom_range(0, 99) < 3);
            tick();
        end
        clear_hazards();

        // async reset in the middle of a stall
        StallF = 1; StallD = 1;
        tick();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_pcf", 160'(PCF), 160'(32'h0));
        check_obs("async", sample(), m);
        @(negedge clk);
        reset = 1'b1;
        clear_hazards();
        PCNextF = 32'h100;
        tick();
        chk("post_rst_pcf", 160'(PCF), 160'(32'h100));

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() != 0) chk("sb_drain", 160'(sb.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
